wave_meter: RTL
===============

# wave_meter

Measures the period and peak-to-peak amplitude of a signed sample stream such as the FIR_LPF output, and is the analysis end of the func_gen → filter chain. It samples `din` on each rising edge of the `f_s` sample strobe and detects rising zero crossings with hysteresis. For each full cycle it reports the period in samples and the peak-to-peak span of the waveform. A no-signal flag is raised when no crossing arrives within a programmable number of samples.

## Interface
- `DW`, 12: sample width (signed two's complement).
- `CW`, 16: period counter and output width.
- `HYST`, 16: hysteresis threshold (positive, < 2^(DW-1)).
- `PMAX`, 4095: maximum period in samples before timeout (≤ 2^CW−1).

- `clk` in 1: system clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `f_s` in 1: sample-rate level signal, synchronous to `clk`; its rising edge marks a sample.
- `din` in DW: signed sample, synchronous to `clk`, valid at the `f_s` rising edge.
- `period` out CW: samples between the last two rising crossings; held until the next measurement.
- `amp_pp` out DW+1: unsigned max−min over the last cycle; held until the next measurement.
- `valid` out 1: one-`clk` pulse when `period`/`amp_pp` update.
- `no_sig` out 1: level, high when no valid measurement is current.

## Operation
- **Strobe detection:** `f_s` is registered into `f_s_d`. A strobe occurs at any `clk` edge where `f_s`=1 and `f_s_d`=0. All processing below happens only on strobe edges, using `din` at that edge. `f_s` held high yields exactly one strobe.
- **State machine** (2 states), with reset state SEEK_LOW:
  - SEEK_LOW → SEEK_HIGH when `din` ≤ −HYST.
  - SEEK_HIGH → SEEK_LOW when `din` ≥ +HYST. This transition is a crossing event.
  - No other transitions occur, except timeout.
- **`first` flag:** reset value 1, meaning no reference crossing has been seen yet.
- **On a crossing event with `first`=1:**
  - `cnt`←1, `min`←`din`, `max`←`din`, `first`←0.
  - No `valid` is produced.
- **On a crossing event with `first`=0:**
  - `period`←`cnt` (pre-update value).
  - `amp_pp`←`max`−`min` (pre-update register values, so the span covers the previous crossing sample through the sample before this one). Computed in DW+1 bits, never negative.
  - `valid`←1, `no_sig`←0.
  - Then `cnt`←1, `min`←`din`, `max`←`din`.
- **On a non-crossing strobe with `first`=0:**
  - If `cnt`==PMAX: timeout. Set `no_sig`←1, `first`←1, state←SEEK_LOW. `cnt`, `period` and `amp_pp` hold.
  - Otherwise: `cnt`←`cnt`+1, `min`←min(`min`,`din`), `max`←max(`max`,`din`).
- **Non-crossing strobe with `first`=1:** only the state machine is updated.
- **Comparisons:** all are signed. A full-scale −2^(DW−1) to 2^(DW−1)−1 swing gives `amp_pp` = 2^DW−1 with no overflow.

## Timing
- **Reset values:** `period`=0, `amp_pp`=0, `valid`=0, `no_sig`=1, state SEEK_LOW, `cnt`=0, `min`=0, `max`=0, `first`=1, `f_s_d`=0.
- **Reset assertion:** applies immediately (asynchronous), including mid-measurement. After release, the first measurement requires two crossing events.
- **Update latency:** outputs and `valid` update at the strobe edge itself. `valid` is high for exactly the one `clk` cycle following that edge.
- **Throughput:** at most one strobe per two `clk` cycles (`f_s` must be low for ≥1 cycle between samples). Behaviour with `f_s` toggling every cycle is undefined.
- **`no_sig` rise:** goes high at the timeout strobe edge, i.e. PMAX non-crossing strobes after the last crossing.
- **`no_sig` fall:** goes low together with the next `valid`.
- **Simultaneous conditions:** crossing and timeout cannot coincide; a crossing takes priority by definition, since timeout is evaluated only on non-crossing strobes.

## Test plan
- **Reset:** assert `rst` asynchronously between `clk` edges → immediately `period`=0, `amp_pp`=0, `valid`=0, `no_sig`=1. Also assert mid-cycle during the square-wave test → the same values, and no `valid` until two crossings have occurred after release.
- **Square wave:** ±1000, 10 samples high / 10 low, 20 kHz `f_s`, 100 MHz `clk` → first `valid` at the second rising crossing. Thereafter `period`=20, `amp_pp`=2000, one `valid` per 20 strobes, `no_sig`=0.
- **Sine:** amplitude 1500, 100 samples per cycle (200 Hz at 20 kHz) → `period`=100 every cycle, `amp_pp` in 2996..3000.
- **Hysteresis:** alternate ±10 for 500 strobes with HYST=16 → no `valid`, state never reaches a crossing, `no_sig` stays 1. Then ±20 alternating → `period`=2, `amp_pp`=40.
- **Timeout:** after locking on the square wave, hold `din`=500 → `no_sig` rises at the strobe where `cnt`==4095; `period`=20 and `amp_pp`=2000 hold. Resume the square wave → `valid` with `period`=20 at the second crossing, and `no_sig` falls with it.
- **Strobe edge cases:** hold `f_s` high for 1000 `clk` cycles → exactly one sample is processed. Drive full-scale ±2047/−2048 → `amp_pp`=4095.

Source files
------------

// File: rtl/wave_meter.sv
// Period and peak-to-peak amplitude meter for a signed sample stream.
// Rising zero crossings are found with a hysteresis band, and a no-signal flag is raised after PMAX samples with no crossing.
module wave_meter #(
    parameter int DW   = 12,
    parameter int CW   = 16,
    parameter int HYST = 16,
    parameter int PMAX = 4095
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 f_s,
    input  logic signed [DW-1:0] din,
    output logic [CW-1:0]        period,
    output logic [DW:0]          amp_pp,
    output logic                 valid,
    output logic                 no_sig
);

    typedef enum logic {
        SEEK_LOW  = 1'b0,
        SEEK_HIGH = 1'b1
    } state_t;

    localparam logic signed [DW-1:0] HYST_P = HYST[DW-1:0];
    localparam logic signed [DW-1:0] HYST_N = -HYST_P;
    localparam logic [CW-1:0]        PMAX_C = PMAX[CW-1:0];

    state_t                state, state_nx;
    logic                  f_s_d;
    logic                  strobe;
    logic                  crossing;
    logic                  timeout;
    logic                  first;
    logic [CW-1:0]         cnt;
    logic signed [DW-1:0]  min_q, max_q;
    logic [DW:0]           span;

    assign strobe   = f_s && !f_s_d;
    assign crossing = strobe && (state == SEEK_HIGH) && (din >= HYST_P);
    assign timeout  = strobe && !crossing && !first && (cnt == PMAX_C);

    // Widen by one bit before subtracting so a full-scale swing cannot wrap.
    assign span = {max_q[DW-1], max_q} - {min_q[DW-1], min_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEEK_LOW;
            f_s_d <= 1'b0;
        end else begin
            state <= state_nx;
            f_s_d <= f_s;
        end
    end

    always_comb begin
        state_nx = state;
        if (strobe) begin
            case (state)
                SEEK_LOW:  if (din <= HYST_N) state_nx = SEEK_HIGH;
                SEEK_HIGH: if (din >= HYST_P) state_nx = SEEK_LOW;
                default:   state_nx = SEEK_LOW;
            endcase
        end
        // A timeout discards any half-seen cycle, so the search restarts from the low side.
        if (timeout) state_nx = SEEK_LOW;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period <= '0;
            amp_pp <= '0;
            valid  <= 1'b0;
            no_sig <= 1'b1;
            cnt    <= '0;
            min_q  <= '0;
            max_q  <= '0;
            first  <= 1'b1;
        end else begin
            valid <= 1'b0;
            if (crossing) begin
                if (!first) begin
                    period <= cnt;
                    amp_pp <= span;
                    valid  <= 1'b1;
                    no_sig <= 1'b0;
                end
                cnt   <= {{(CW-1){1'b0}}, 1'b1};
                min_q <= din;
                max_q <= din;
                first <= 1'b0;
            end else if (strobe && !first) begin
                if (timeout) begin
                    no_sig <= 1'b1;
                    first  <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                    if (din < min_q) min_q <= din;
                    if (din > max_q) max_q <= din;
                end
            end
        end
    end

endmodule
